// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit counters, execute-stage mispredict check and perf counters
// Ports: clk/reset_n (async active-low); f_pc -> pred_taken/pred_target (fetch lookup);
// x_* execute-stage resolution -> mispredict/redirect_pc; ctl_count/mis_count saturating stats.
module branch_predict_unit #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] f_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            x_valid,
    input  logic [XLEN-1:0] x_pc,
    input  logic            x_is_branch,
    input  logic            x_is_jump,
    input  logic            x_taken,
    input  logic [XLEN-1:0] x_target,
    input  logic            x_pred_taken,
    input  logic [XLEN-1:0] x_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     ctl_count,
    output logic [31:0]     mis_count
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    logic            r_valid  [ENTRIES];
    logic [TAGW-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0] r_target [ENTRIES];
    logic [1:0]      r_ctr    [ENTRIES];
    logic            r_jmp    [ENTRIES];
    logic [31:0]     r_ctl;
    logic [31:0]     r_mis;

    logic [IDXW-1:0] w_fidx, w_xidx;
    logic [TAGW-1:0] w_ftag, w_xtag;
    logic            w_fhit, w_xhit;
    logic            w_is_jmp, w_is_br, w_ctl, w_false_hit;
    logic [1:0]      w_ctr_cur, w_ctr_nxt;
    logic            w_unused;

    assign w_fidx   = f_pc[IDXW+1:2];
    assign w_ftag   = f_pc[XLEN-1:IDXW+2];
    assign w_xidx   = x_pc[IDXW+1:2];
    assign w_xtag   = x_pc[XLEN-1:IDXW+2];
    assign w_unused = &{1'b0, f_pc[1:0]};

    // Lookup reads current array contents only, so a same-cycle update is seen next cycle.
    assign w_fhit      = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
    assign pred_taken  = w_fhit && (r_jmp[w_fidx] || r_ctr[w_fidx][1]);
    assign pred_target = pred_taken ? r_target[w_fidx] : '0;

    // A set jump bit wins over the branch bit.
    assign w_is_jmp    = x_valid && x_is_jump;
    assign w_is_br     = x_valid && x_is_branch && !x_is_jump;
    assign w_ctl       = w_is_jmp || w_is_br;
    assign w_false_hit = x_valid && !x_is_branch && !x_is_jump && x_pred_taken;

    assign mispredict  = (w_ctl && ((x_pred_taken != x_taken) ||
                                    (x_taken && (x_pred_target != x_target)))) || w_false_hit;
    assign redirect_pc = !mispredict ? '0 : (w_ctl && x_taken) ? x_target : x_pc + XLEN'(4);

    assign w_xhit    = r_valid[w_xidx] && (r_tag[w_xidx] == w_xtag);
    assign w_ctr_cur = r_ctr[w_xidx];
    assign w_ctr_nxt = x_taken ? ((w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'b01)
                               : ((w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'b01);

    assign ctl_count = r_ctl;
    assign mis_count = r_mis;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_INIT;
                r_jmp[i]    <= 1'b0;
            end
            r_ctl <= '0;
            r_mis <= '0;
        end else begin
            if (w_ctl && (r_ctl != '1))
                r_ctl <= r_ctl + 32'd1;
            if (mispredict && (r_mis != '1))
                r_mis <= r_mis + 32'd1;
            if (w_is_jmp) begin
                r_valid[w_xidx]  <= 1'b1;
                r_tag[w_xidx]    <= w_xtag;
                r_target[w_xidx] <= x_target;
                r_ctr[w_xidx]    <= 2'b11;
                r_jmp[w_xidx]    <= 1'b1;
            end else if (w_is_br && w_xhit) begin
                r_ctr[w_xidx] <= w_ctr_nxt;
                r_jmp[w_xidx] <= 1'b0;
                if (x_taken)
                    r_target[w_xidx] <= x_target;
            end else if (w_is_br && x_taken) begin
                r_valid[w_xidx]  <= 1'b1;
                r_tag[w_xidx]    <= w_xtag;
                r_target[w_xidx] <= x_target;
                r_ctr[w_xidx]    <= 2'b10;
                r_jmp[w_xidx]    <= 1'b0;
            end else if (w_false_hit) begin
                r_valid[w_xidx] <= 1'b0;
            end
        end
    end
endmodule
